lc3_mem_ctrl: RTL and testbench

Memory access sequencer that sits directly downstream of the LC-3 control unit (ISDU). It turns the ISDU's active-low Mem_OE/Mem_WE request strobes plus the MAR address and MDR data into correctly timed asynchronous-SRAM cycles, with a configurable number of wait states. It also decodes the memory-mapped I/O word at IO_ADDR: reads return the switches, writes update the hex-display register. Mem_Ready tells the ISDU when the access has completed; the ISDU holds its strobe low until it sees Mem_Ready.

---
 rtl/lc3_mem_pkg.sv | 6 +
 rtl/mem_wait_ctr.sv | 15 +
 rtl/lc3_mem_ctrl.sv | 81 ++++++++
 tb/tb_lc3_mem_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types and constants for the LC-3 memory sequencer
package lc3_mem_pkg;
  typedef enum logic [2:0] {IDLE, RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD, IO_ACC, DONE, RELEASE} mem_state_t;
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int CTR_W = 4;
endpackage

// File: rtl/mem_wait_ctr.sv
// mem_wait_ctr: loadable wait-state down-counter, tc high while the count is zero
module mem_wait_ctr
  import lc3_mem_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic             tc
);
  logic [CTR_W-1:0] cnt;
  assign tc = cnt == '0;
  always_ff @(posedge Clk)
    cnt <= Reset ? '0 : load ? load_val : tc ? cnt : cnt - 1'b1;
endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: turns ISDU Mem_OE/Mem_WE requests into timed async-SRAM cycles plus switch/hex I/O
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int          READ_WAIT  = 2,
  parameter int          WRITE_WAIT = 2,
  parameter logic [15:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Mem_Ready,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] Switches,
  output logic [15:0] HEX_Data
);
  localparam logic [CTR_W-1:0] RD_CNT = CTR_W'(READ_WAIT - 1);
  localparam logic [CTR_W-1:0] WR_CNT = CTR_W'(WRITE_WAIT - 1);
  mem_state_t state, state_n;
  logic wr, tc, ctr_load, is_io, req;
  logic [CTR_W-1:0] ctr_val;
  assign is_io = ADDR == IO_ADDR;
  assign req = !Mem_WE || !Mem_OE;
  assign ctr_load = state == IDLE || state == WR_SETUP;
  assign ctr_val = state == IDLE ? RD_CNT : WR_CNT;
  mem_wait_ctr u_ctr (.Clk(Clk), .Reset(Reset), .load(ctr_load), .load_val(ctr_val), .tc(tc));
  // strobes decode from the registered state only, so requests never glitch the SRAM pins
  assign SRAM_CE_N = !(state inside {RD_ACT, WR_SETUP, WR_PULSE, WR_HOLD});
  assign SRAM_OE_N = state != RD_ACT;
  assign SRAM_WE_N = state != WR_PULSE;
  assign SRAM_DQ_oe = state inside {WR_SETUP, WR_PULSE, WR_HOLD};
  assign Mem_Ready = state == DONE;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !Mem_WE ? (is_io ? IO_ACC : WR_SETUP) : !Mem_OE ? (is_io ? IO_ACC : RD_ACT) : IDLE;
      RD_ACT:   state_n = tc ? DONE : RD_ACT;
      WR_SETUP: state_n = WR_PULSE;
      WR_PULSE: state_n = tc ? WR_HOLD : WR_PULSE;
      WR_HOLD:  state_n = DONE;
      IO_ACC:   state_n = DONE;
      DONE:     state_n = RELEASE;
      RELEASE:  state_n = Mem_OE && Mem_WE ? IDLE : RELEASE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      wr <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_DQ_out <= '0;
      Data_to_CPU <= '0;
      HEX_Data <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        SRAM_ADDR <= {4'h0, ADDR};
        SRAM_DQ_out <= Data_from_CPU;
        wr <= !Mem_WE;
      end
      if (state == RD_ACT && tc) Data_to_CPU <= SRAM_DQ_in;
      if (state == IO_ACC && wr) HEX_Data <= Data_from_CPU;
      if (state == IO_ACC && !wr) Data_to_CPU <= Switches;
    end
  end
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: table-driven access vectors plus held-strobe and mid-write reset sequences
module tb_lc3_mem_ctrl;
  import lc3_mem_pkg::*;
  logic Clk = 1'b0, Reset = 1'b1, Mem_OE = 1'b1, Mem_WE = 1'b1;
  logic [15:0] ADDR = '0, Data_from_CPU = '0, SRAM_DQ_in = '0, Switches = '0;
  logic [15:0] Data_to_CPU, SRAM_DQ_out, HEX_Data;
  logic [19:0] SRAM_ADDR;
  logic Mem_Ready, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_DQ_oe;
  int n_chk = 0, n_fail = 0;
  always #5 Clk = ~Clk;
  lc3_mem_ctrl #(.READ_WAIT(2), .WRITE_WAIT(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_oe(SRAM_DQ_oe), .Switches(Switches), .HEX_Data(HEX_Data)
  );
  typedef struct {
    logic [1:0] op;
    logic [15:0] addr, wdata, sw, dq;
    int lat, oe_f, oe_n, we_f, we_n, dq_f, dq_n, ce_n;
    logic [15:0] rd, hex;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    int lat = -1, oe_f = -1, oe_n = 0, we_f = -1, we_n = 0, dq_f = -1, dq_n = 0, ce_n = 0, ovl = 0;
    logic [19:0] addr_at = '0;
    logic [15:0] dqo_at = '0, rd_at = '0;
    string p = $sformatf("v%0d.", idx);
    Switches = v.sw; SRAM_DQ_in = v.dq; ADDR = v.addr; Data_from_CPU = v.wdata;
    Mem_WE = v.op == 2'd0;
    Mem_OE = v.op == 2'd1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge Clk); #1;
      if (!SRAM_OE_N) begin if (oe_f < 0) oe_f = c; oe_n++; end
      if (!SRAM_WE_N) begin if (we_f < 0) we_f = c; we_n++; end
      if (SRAM_DQ_oe) begin if (dq_f < 0) dq_f = c; dq_n++; end
      if (!SRAM_CE_N) ce_n++;
      if (SRAM_DQ_oe && !SRAM_OE_N) ovl++;
      if (Mem_Ready) begin
        lat = c; addr_at = SRAM_ADDR; dqo_at = SRAM_DQ_out; rd_at = Data_to_CPU;
        Mem_OE = 1'b1; Mem_WE = 1'b1;
      end
    end
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    chk({p, "latency"}, lat, v.lat);
    chk({p, "oe_first"}, oe_f, v.oe_f);
    chk({p, "oe_cycles"}, oe_n, v.oe_n);
    chk({p, "we_first"}, we_f, v.we_f);
    chk({p, "we_cycles"}, we_n, v.we_n);
    chk({p, "dqoe_first"}, dq_f, v.dq_f);
    chk({p, "dqoe_cycles"}, dq_n, v.dq_n);
    chk({p, "ce_cycles"}, ce_n, v.ce_n);
    chk({p, "oe_dqoe_overlap"}, ovl, 0);
    chk({p, "sram_addr"}, addr_at, {4'h0, v.addr});
    chk({p, "dq_out"}, dqo_at, v.wdata);
    chk({p, "data_to_cpu"}, rd_at, v.rd);
    @(posedge Clk); #1;
    chk({p, "ready_pulse_end"}, Mem_Ready, 1'b0);
    chk({p, "hex"}, HEX_Data, v.hex);
    @(posedge Clk); #1;
  endtask
  initial begin
    int rdy, oen;
    //           op     addr      wdata     sw        dq        lat oef oen wef wen dqf dqn ce  rd        hex
    tbl[0] = '{2'd0, 16'h3000, 16'h0000, 16'h0000, 16'h1234, 3, 1, 2, -1, 0, -1, 0, 2, 16'h1234, 16'h0000};
    tbl[1] = '{2'd1, 16'h0040, 16'hBEEF, 16'h0000, 16'h0000, 5, -1, 0, 2, 2, 1, 4, 4, 16'h1234, 16'h0000};
    tbl[2] = '{2'd0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h0000, 2, -1, 0, -1, 0, -1, 0, 0, 16'h00A5, 16'h0000};
    tbl[3] = '{2'd1, 16'hFFFF, 16'h5A5A, 16'h00A5, 16'h0000, 2, -1, 0, -1, 0, -1, 0, 0, 16'h00A5, 16'h5A5A};
    tbl[4] = '{2'd0, 16'h0001, 16'h0000, 16'h0000, 16'h7777, 3, 1, 2, -1, 0, -1, 0, 2, 16'h7777, 16'h5A5A};
    tbl[5] = '{2'd1, 16'h0002, 16'h1111, 16'h0000, 16'h0000, 5, -1, 0, 2, 2, 1, 4, 4, 16'h7777, 16'h5A5A};
    tbl[6] = '{2'd2, 16'h0100, 16'hCAFE, 16'h0000, 16'h9999, 5, -1, 0, 2, 2, 1, 4, 4, 16'h7777, 16'h5A5A};
    tbl[7] = '{2'd2, 16'hFFFF, 16'h0F0F, 16'hAAAA, 16'h0000, 2, -1, 0, -1, 0, -1, 0, 0, 16'h7777, 16'h0F0F};
    repeat (3) @(posedge Clk);
    #1;
    chk("rst.ce_n", SRAM_CE_N, 1'b1);
    chk("rst.oe_n", SRAM_OE_N, 1'b1);
    chk("rst.we_n", SRAM_WE_N, 1'b1);
    chk("rst.dq_oe", SRAM_DQ_oe, 1'b0);
    chk("rst.ready", Mem_Ready, 1'b0);
    chk("rst.data", Data_to_CPU, 16'h0);
    chk("rst.hex", HEX_Data, 16'h0);
    chk("rst.addr", SRAM_ADDR, 20'h0);
    chk("rst.dq_out", SRAM_DQ_out, 16'h0);
    chk("rst.ub_lb", {SRAM_UB_N, SRAM_LB_N}, 2'b00);
    Reset = 1'b0;
    @(posedge Clk); #1;
    foreach (tbl[i]) run_vec(i, tbl[i]);
    rdy = 0; oen = 0;
    ADDR = 16'h0200; SRAM_DQ_in = 16'h4321; Mem_OE = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clk); #1;
      if (Mem_Ready) rdy++;
      if (!SRAM_OE_N) oen++;
    end
    chk("hold.ready_pulses", rdy, 1);
    chk("hold.oe_cycles", oen, 2);
    chk("hold.data", Data_to_CPU, 16'h4321);
    chk("hold.state_release", dut.state, RELEASE);
    Mem_OE = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("hold.state_idle", dut.state, IDLE);
    ADDR = 16'h0300; Data_from_CPU = 16'hD00D; Mem_WE = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rstmid.in_pulse", SRAM_WE_N, 1'b0);
    Reset = 1'b1; Mem_WE = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    chk("rstmid.we_n", SRAM_WE_N, 1'b1);
    chk("rstmid.ce_n", SRAM_CE_N, 1'b1);
    chk("rstmid.dq_oe", SRAM_DQ_oe, 1'b0);
    chk("rstmid.hex", HEX_Data, 16'h0);
    chk("rstmid.ready", Mem_Ready, 1'b0);
    chk("rstmid.state", dut.state, IDLE);
    @(posedge Clk); #1;
    chk("rstmid.no_retry", SRAM_CE_N, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
